// File: rtl/conv_tile_scheduler.sv
// Layer-level sequencer for ConvTop: walks every (POF group, tile row, tile column)
// of one layer, launching each tile with incrementally computed BRAM base addresses.
module conv_tile_scheduler #(
  parameter int NUM_TILE_X     = 2,
  parameter int NUM_TILE_Y     = 2,
  parameter int NUM_POF_GROUPS = 2,
  parameter int IN_TILE_WORDS  = 64,
  parameter int WT_GROUP_WORDS = 144,
  parameter int OUT_TILE_WORDS = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYC    = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_in_base,
  input  logic [ADDR_W-1:0] cfg_wt_base,
  input  logic [ADDR_W-1:0] cfg_out_base,
  input  logic              conv_tile_done,
  input  logic              conv_tile_pof_done,
  output logic              conv_ready,
  output logic [ADDR_W-1:0] tile_in_base,
  output logic [ADDR_W-1:0] tile_wt_base,
  output logic [ADDR_W-1:0] tile_out_base,
  output logic [15:0]       tile_x,
  output logic [15:0]       tile_y,
  output logic [15:0]       pof_idx,
  output logic [15:0]       pof_done_cnt,
  output logic              busy,
  output logic              layer_done,
  output logic              err_timeout
);

  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cfg_in_q;
  logic [WD_W-1:0]   wdog;
  logic              last_x;
  logic              last_y;
  logic              last_pof;

  assign last_x   = (tile_x  == 16'(NUM_TILE_X - 1));
  assign last_y   = (tile_y  == 16'(NUM_TILE_Y - 1));
  assign last_pof = (pof_idx == 16'(NUM_POF_GROUPS - 1));

  // The input base restarts at the latched layer base whenever a new POF group begins,
  // so only that one config value has to be kept beyond the start cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cfg_in_q      <= '0;
      wdog          <= '0;
      conv_ready    <= 1'b0;
      tile_in_base  <= '0;
      tile_wt_base  <= '0;
      tile_out_base <= '0;
      tile_x        <= '0;
      tile_y        <= '0;
      pof_idx       <= '0;
      pof_done_cnt  <= '0;
      busy          <= 1'b0;
      layer_done    <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      conv_ready <= 1'b0;
      layer_done <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              cfg_in_q      <= cfg_in_base;
              tile_in_base  <= cfg_in_base;
              tile_wt_base  <= cfg_wt_base;
              tile_out_base <= cfg_out_base;
              tile_x        <= '0;
              tile_y        <= '0;
              pof_idx       <= '0;
              err_timeout   <= 1'b0;
              conv_ready    <= 1'b1;
              busy          <= 1'b1;
              state         <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            pof_done_cnt <= '0;
            wdog         <= '0;
            state        <= S_WAIT;
          end
          S_WAIT: begin
            if (conv_tile_pof_done && (pof_done_cnt != 16'hFFFF))
              pof_done_cnt <= pof_done_cnt + 16'd1;
            if (conv_tile_done) begin
              state <= S_ADVANCE;
            end else if (wdog == WD_W'(TIMEOUT_CYC - 1)) begin
              err_timeout <= 1'b1;
              layer_done  <= 1'b1;
              state       <= S_DONE;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end
          S_ADVANCE: begin
            if (last_x && last_y && last_pof) begin
              layer_done <= 1'b1;
              state      <= S_DONE;
            end else begin
              tile_out_base <= tile_out_base + ADDR_W'(OUT_TILE_WORDS);
              if (!last_x) begin
                tile_x       <= tile_x + 16'd1;
                tile_in_base <= tile_in_base + ADDR_W'(IN_TILE_WORDS);
              end else if (!last_y) begin
                tile_x       <= '0;
                tile_y       <= tile_y + 16'd1;
                tile_in_base <= tile_in_base + ADDR_W'(IN_TILE_WORDS);
              end else begin
                tile_x       <= '0;
                tile_y       <= '0;
                pof_idx      <= pof_idx + 16'd1;
                tile_in_base <= cfg_in_q;
                tile_wt_base <= tile_wt_base + ADDR_W'(WT_GROUP_WORDS);
              end
              conv_ready <= 1'b1;
              state      <= S_ISSUE;
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed bench for conv_tile_scheduler: per-tile vector table for the 2x2x2 layer
// plus hand-written sequences for reset, watchdog, abort and address wrap.
module tb_conv_tile_scheduler;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] cfg_in_base;
  logic [31:0] cfg_wt_base;
  logic [31:0] cfg_out_base;
  logic        conv_tile_done;
  logic        conv_tile_pof_done;
  logic        conv_ready;
  logic [31:0] tile_in_base;
  logic [31:0] tile_wt_base;
  logic [31:0] tile_out_base;
  logic [15:0] tile_x;
  logic [15:0] tile_y;
  logic [15:0] pof_idx;
  logic [15:0] pof_done_cnt;
  logic        busy;
  logic        layer_done;
  logic        err_timeout;

  conv_tile_scheduler dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .abort              (abort),
    .cfg_in_base        (cfg_in_base),
    .cfg_wt_base        (cfg_wt_base),
    .cfg_out_base       (cfg_out_base),
    .conv_tile_done     (conv_tile_done),
    .conv_tile_pof_done (conv_tile_pof_done),
    .conv_ready         (conv_ready),
    .tile_in_base       (tile_in_base),
    .tile_wt_base       (tile_wt_base),
    .tile_out_base      (tile_out_base),
    .tile_x             (tile_x),
    .tile_y             (tile_y),
    .pof_idx            (pof_idx),
    .pof_done_cnt       (pof_done_cnt),
    .busy               (busy),
    .layer_done         (layer_done),
    .err_timeout        (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pof;
    logic [15:0] ty;
    logic [15:0] tx;
    logic [31:0] inOff;
    logic [31:0] wtOff;
    logic [31:0] outOff;
    int          pulses;
    bit          stray;
  } tile_vec_t;

  tile_vec_t   vec [8];
  int          testsRun;
  int          failCount;
  int          readyCnt;
  int          doneCnt;
  logic [31:0] expIn;
  logic [31:0] expWt;
  logic [31:0] expOut;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive inputs, advance one clock, and sample outputs on the falling edge.
  task automatic applyStimulus(input bit s, input bit a, input bit td, input bit pd);
    start              = s;
    abort              = a;
    conv_tile_done     = td;
    conv_tile_pof_done = pd;
    @(negedge clk);
    if (conv_ready) readyCnt++;
    if (layer_done) doneCnt++;
  endtask

  task automatic waitReady(input string name);
    int n = 0;
    while (!conv_ready && n < 20) begin
      applyStimulus(0, 0, 0, 0);
      n++;
    end
    checkOutput(name, conv_ready, 1'b1);
  endtask

  // ConvTop stand-in: tile_done ten cycles after ready, optional pof pulses and abort.
  task automatic runTile(input int i, input bit abortOnDone);
    bit pd;
    waitReady($sformatf("t%0d_ready", i));
    if (!conv_ready) return;
    checkOutput($sformatf("t%0d_pof", i), pof_idx, vec[i].pof);
    checkOutput($sformatf("t%0d_ty", i), tile_y, vec[i].ty);
    checkOutput($sformatf("t%0d_tx", i), tile_x, vec[i].tx);
    checkOutput($sformatf("t%0d_in", i), tile_in_base, expIn + vec[i].inOff);
    checkOutput($sformatf("t%0d_wt", i), tile_wt_base, expWt + vec[i].wtOff);
    checkOutput($sformatf("t%0d_out", i), tile_out_base, expOut + vec[i].outOff);
    checkOutput($sformatf("t%0d_busy", i), busy, 1'b1);
    applyStimulus(0, 0, vec[i].stray, vec[i].stray);
    checkOutput($sformatf("t%0d_ready_1cyc", i), conv_ready, 1'b0);
    checkOutput($sformatf("t%0d_cnt_clr", i), pof_done_cnt, 16'd0);
    for (int c = 0; c < 8; c++) begin
      pd = (c == 1 && vec[i].pulses > 0) || (c == 3 && vec[i].pulses > 1) ||
           (c == 5 && vec[i].pulses > 2);
      applyStimulus(0, 0, 0, pd);
    end
    checkOutput($sformatf("t%0d_pofcnt", i), pof_done_cnt, 16'(vec[i].pulses));
    checkOutput($sformatf("t%0d_out_stable", i), tile_out_base, expOut + vec[i].outOff);
    applyStimulus(0, abortOnDone, 1, 0);
  endtask

  initial begin
    vec[0] = '{16'd0, 16'd0, 16'd0, 32'h00, 32'h00, 32'h00, 3, 1'b1};
    vec[1] = '{16'd0, 16'd0, 16'd1, 32'h40, 32'h00, 32'h20, 0, 1'b0};
    vec[2] = '{16'd0, 16'd1, 16'd0, 32'h80, 32'h00, 32'h40, 1, 1'b0};
    vec[3] = '{16'd0, 16'd1, 16'd1, 32'hC0, 32'h00, 32'h60, 3, 1'b0};
    vec[4] = '{16'd1, 16'd0, 16'd0, 32'h00, 32'h90, 32'h80, 2, 1'b0};
    vec[5] = '{16'd1, 16'd0, 16'd1, 32'h40, 32'h90, 32'hA0, 3, 1'b0};
    vec[6] = '{16'd1, 16'd1, 16'd0, 32'h80, 32'h90, 32'hC0, 3, 1'b0};
    vec[7] = '{16'd1, 16'd1, 16'd1, 32'hC0, 32'h90, 32'hE0, 1, 1'b0};

    testsRun = 0; failCount = 0; readyCnt = 0; doneCnt = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    conv_tile_done = 1'b0; conv_tile_pof_done = 1'b0;
    expIn = 32'h1000; expWt = 32'h2000; expOut = 32'h3000;
    cfg_in_base = expIn; cfg_wt_base = expWt; cfg_out_base = expOut;

    repeat (2) @(negedge clk);
    checkOutput("rst_ready", conv_ready, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_layer_done", layer_done, 1'b0);
    checkOutput("rst_err", err_timeout, 1'b0);
    checkOutput("rst_in", tile_in_base, 32'h0);
    checkOutput("rst_out", tile_out_base, 32'h0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0);

    // Asynchronous reset in the middle of WAIT
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("pre_reset_busy", busy, 1'b1);
    checkOutput("pre_reset_cnt", pof_done_cnt, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_busy", busy, 1'b0);
    checkOutput("async_in", tile_in_base, 32'h0);
    checkOutput("async_wt", tile_wt_base, 32'h0);
    checkOutput("async_out", tile_out_base, 32'h0);
    checkOutput("async_cnt", pof_done_cnt, 16'd0);
    applyStimulus(0, 0, 0, 0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0);

    // Strays in IDLE
    readyCnt = 0; doneCnt = 0;
    applyStimulus(0, 0, 1, 1);
    checkOutput("idle_stray_busy", busy, 1'b0);
    checkOutput("idle_stray_cnt", pof_done_cnt, 16'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("idle_stray_ready", conv_ready, 1'b0);

    // Full 2x2x2 layer; the input base is changed after start to prove it was latched
    applyStimulus(1, 0, 0, 0);
    cfg_in_base = 32'hDEAD0000;
    for (int i = 0; i < 8; i++) runTile(i, 1'b0);
    checkOutput("advance_no_done", layer_done, 1'b0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("layer_done_pulse", layer_done, 1'b1);
    checkOutput("done_busy", busy, 1'b1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("post_done_busy", busy, 1'b0);
    checkOutput("post_done_pulse", layer_done, 1'b0);
    repeat (5) applyStimulus(0, 0, 0, 0);
    checkOutput("start_in_done_ignored", busy, 1'b0);
    checkOutput("ready_count", readyCnt, 8);
    checkOutput("done_count", doneCnt, 1);
    checkOutput("last_out_hold", tile_out_base, 32'h30E0);
    checkOutput("last_pof_hold", pof_idx, 16'd1);

    // Watchdog on the third tile
    cfg_in_base = expIn;
    readyCnt = 0; doneCnt = 0;
    applyStimulus(1, 0, 0, 0);
    runTile(0, 1'b0);
    runTile(1, 1'b0);
    waitReady("to_ready");
    begin
      int n = 0;
      while (!layer_done && n < 5000) begin
        applyStimulus(0, 0, 0, 0);
        n++;
        if (n == 4096) checkOutput("to_err_early", err_timeout, 1'b0);
      end
      checkOutput("to_cycles", n, 4097);
    end
    checkOutput("to_err", err_timeout, 1'b1);
    checkOutput("to_busy_in_done", busy, 1'b1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("to_idle_busy", busy, 1'b0);
    checkOutput("to_err_sticky", err_timeout, 1'b1);
    checkOutput("to_ty_hold", tile_y, 16'd1);
    checkOutput("to_tx_hold", tile_x, 16'd0);
    checkOutput("to_in_hold", tile_in_base, 32'h1080);
    checkOutput("to_ready_count", readyCnt, 3);
    checkOutput("to_done_count", doneCnt, 1);

    // Restart clears the error, then abort collides with tile_done on the second tile
    readyCnt = 0; doneCnt = 0;
    applyStimulus(1, 0, 0, 0);
    checkOutput("restart_err_clr", err_timeout, 1'b0);
    runTile(0, 1'b0);
    runTile(1, 1'b1);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_ready", conv_ready, 1'b0);
    repeat (20) applyStimulus(0, 0, 0, 0);
    checkOutput("abort_ready_count", readyCnt, 2);
    checkOutput("abort_done_count", doneCnt, 0);
    checkOutput("abort_tx_hold", tile_x, 16'd1);
    checkOutput("abort_out_hold", tile_out_base, 32'h3020);

    // Output base near the top of the address space wraps
    expOut = 32'hFFFFFFF0; cfg_out_base = expOut;
    readyCnt = 0; doneCnt = 0;
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      runTile(i, 1'b0);
      if (i == 1) checkOutput("wrap_out_tile2", tile_out_base, 32'h00000010);
    end
    begin
      int n = 0;
      while (!layer_done && n < 5) begin
        applyStimulus(0, 0, 0, 0);
        n++;
      end
    end
    checkOutput("wrap_layer_done", layer_done, 1'b1);
    checkOutput("wrap_last_out", tile_out_base, 32'h000000D0);
    checkOutput("wrap_ready_count", readyCnt, 8);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
